// File: rtl/output_limit_fifo_pkt_pkg.sv
// Shared types, defaults and sizing helper for the packet-aware output limit FIFO.
package output_limit_fifo_pkt_pkg;

  localparam int unsigned ADDR_MSB_DEF = 11;
  localparam int unsigned WIDTH_DEF    = 16;
  localparam int unsigned LIMIT_W      = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_msb);
    return 32'd1 << (addr_msb + 32'd1);
  endfunction

endpackage

// File: rtl/output_limit_fifo_pkt_bram_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module bram_sdp_ram #(
  parameter int unsigned DW    = 17,
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 4096
) (
  input  logic          CLK,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  input  logic          enb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb
);

  (* ram_style = "block" *) logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (wea) mem_q[addra] <= dina;
    if (enb) doutb <= mem_q[addrb];
  end

endmodule

// File: rtl/output_limit_fifo_pkt.sv
// FWFT output FIFO releasing only whole packets, with optional host-granted output limit,
// partial-packet abort and oversize-packet drop.
module output_limit_fifo_pkt
  import output_limit_fifo_pkt_pkg::*;
#(
  parameter int unsigned ADDR_MSB = ADDR_MSB_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               wr_en,
  input  logic               din_last,
  input  logic               wr_abort,
  output logic               full,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_last,
  input  logic               rd_en,
  output logic               empty,
  input  logic               mode_limit,
  input  logic               reg_output_limit,
  output logic [LIMIT_W-1:0] output_limit,
  output logic               output_limit_not_done,
  output logic               err_pkt_overflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_MSB);
  localparam int unsigned PTR_W = ADDR_MSB + 1;

  logic [PTR_W-1:0]   addra_q, addra_d, addra_inc;
  logic [PTR_W-1:0]   commit_q, commit_d;
  logic [PTR_W-1:0]   limit_q, limit_d, limit_rd_q, lim_diff;
  logic [PTR_W-1:0]   addrb_q, addrb_d;
  logic [LIMIT_W-1:0] olim_q, olim_d;
  logic               err_q, err_d, not_done_q;
  logic               full_int, ovf, wr_acc, grant;
  logic               ram_v_q, ram_v_d, out_take, out_load, rd_issue;
  logic [WIDTH:0]     ram_dout, dout_q;
  out_state_e         state_q, state_d;

  assign addra_inc = addra_q + PTR_W'(1);
  assign full_int  = rst | (addra_inc == addrb_q);
  // A full FIFO whose committed data is all read out holds only one oversize packet.
  assign ovf       = full_int & (commit_q == addrb_q) & ~rst;
  assign wr_acc    = wr_en & ~full_int & ~wr_abort;
  assign grant     = ~mode_limit | reg_output_limit;
  assign lim_diff  = commit_q - limit_q;

  always_comb begin
    addra_d  = addra_q;
    commit_d = commit_q;
    limit_d  = limit_q;
    olim_d   = olim_q;
    err_d    = err_q | ovf;
    if (wr_abort | ovf) begin
      addra_d = commit_q;
    end else if (wr_acc) begin
      addra_d = addra_inc;
      if (din_last) commit_d = addra_inc;
    end
    if (grant) begin
      limit_d = commit_q;
      olim_d  = LIMIT_W'(lim_diff);
    end
  end

  // Output register FSM
  always_ff @(posedge CLK) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (ram_v_q) state_d = OUT_VALID;
      OUT_VALID: if (rd_en & ~ram_v_q) state_d = OUT_EMPTY;
    endcase
  end

  // The read compare uses a retimed copy of limit_addr, which only ever lags it.
  always_comb begin
    empty    = rst | (state_q == OUT_EMPTY);
    out_take = (state_q == OUT_EMPTY) | rd_en;
    out_load = ram_v_q & out_take;
    rd_issue = (limit_rd_q != addrb_q) & (~ram_v_q | out_take);
  end

  assign ram_v_d = rd_issue | (ram_v_q & ~out_take);
  assign addrb_d = rd_issue ? addrb_q + PTR_W'(1) : addrb_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      addra_q    <= '0;
      commit_q   <= '0;
      limit_q    <= '0;
      limit_rd_q <= '0;
      addrb_q    <= '0;
      olim_q     <= '0;
      err_q      <= 1'b0;
      not_done_q <= 1'b0;
      ram_v_q    <= 1'b0;
    end else begin
      addra_q    <= addra_d;
      commit_q   <= commit_d;
      limit_q    <= limit_d;
      limit_rd_q <= limit_q;
      addrb_q    <= addrb_d;
      olim_q     <= olim_d;
      err_q      <= err_d;
      not_done_q <= (limit_q != addrb_q);
      ram_v_q    <= ram_v_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (out_load) dout_q <= ram_dout;
  end

  bram_sdp_ram #(
    .DW   (WIDTH + 1),
    .AW   (PTR_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .CLK  (CLK),
    .wea  (wr_acc),
    .addra(addra_q),
    .dina ({din_last, din}),
    .enb  (rd_issue),
    .addrb(addrb_q),
    .doutb(ram_dout)
  );

  assign full                  = full_int;
  assign dout                  = dout_q[WIDTH-1:0];
  assign dout_last             = dout_q[WIDTH];
  assign output_limit          = olim_q;
  assign output_limit_not_done = not_done_q;
  assign err_pkt_overflow      = err_q;

endmodule

// File: tb/tb_output_limit_fifo_pkt.sv
// Bench for output_limit_fifo_pkt: queue-based packet model plus directed scenarios.
module tb_output_limit_fifo_pkt;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, wr_en, din_last, wr_abort, rd_en, mode_limit, reg_output_limit;
  logic [15:0] din, dout, output_limit;
  logic        full, dout_last, empty, output_limit_not_done, err_pkt_overflow;

  logic        s_wr_en, s_din_last, s_wr_abort, s_rd_en, s_mode, s_reg;
  logic [15:0] s_din, s_dout, s_olim;
  logic        s_full, s_dout_last, s_empty, s_nd, s_err;

  output_limit_fifo_pkt #(.ADDR_MSB(11), .WIDTH(16)) u_dut (
    .CLK(CLK), .rst(rst), .din(din), .wr_en(wr_en), .din_last(din_last), .wr_abort(wr_abort),
    .full(full), .dout(dout), .dout_last(dout_last), .rd_en(rd_en), .empty(empty),
    .mode_limit(mode_limit), .reg_output_limit(reg_output_limit), .output_limit(output_limit),
    .output_limit_not_done(output_limit_not_done), .err_pkt_overflow(err_pkt_overflow)
  );

  output_limit_fifo_pkt #(.ADDR_MSB(3), .WIDTH(16)) u_small (
    .CLK(CLK), .rst(rst), .din(s_din), .wr_en(s_wr_en), .din_last(s_din_last), .wr_abort(s_wr_abort),
    .full(s_full), .dout(s_dout), .dout_last(s_dout_last), .rd_en(s_rd_en), .empty(s_empty),
    .mode_limit(s_mode), .reg_output_limit(s_reg), .output_limit(s_olim),
    .output_limit_not_done(s_nd), .err_pkt_overflow(s_err)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Packet model: partial words, committed-not-granted words, granted (readable) words.
  logic [16:0] pend[$];
  logic [16:0] comm[$];
  logic [16:0] rel[$];
  logic [15:0] m_olim = '0;
  logic        m_err  = 1'b0;
  logic        m_pop  = 1'b0;
  int          stall  = 0;

  always @(posedge CLK) begin
    if (rst) begin
      pend.delete();
      comm.delete();
      rel.delete();
      m_olim <= '0;
      m_err  <= 1'b0;
    end else begin
      if (m_pop && rel.size() != 0) void'(rel.pop_front());
      if (!mode_limit || reg_output_limit) begin
        m_olim <= 16'(comm.size());
        while (comm.size() != 0) rel.push_back(comm.pop_front());
      end
      if (wr_abort) begin
        pend.delete();
      end else if (wr_en) begin
        pend.push_back({din_last, din});
        if (din_last) while (pend.size() != 0) comm.push_back(pend.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    m_pop <= rd_en & ~empty & ~rst;
    if (!rst) begin
      chk("full", full, 1'b0);
      chk("err", err_pkt_overflow, m_err);
      chk("olim", output_limit, m_olim);
      if (!empty) begin
        chk("released", 32'(rel.size() != 0), 1);
        if (rel.size() != 0) chk("dout", {dout_last, dout}, rel[0]);
      end
      if (empty && rel.size() != 0) stall++;
      else stall = 0;
      chk("stall_bound", 32'(stall > 8), 0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wr(input logic [15:0] d, input logic l);
    wr_en = 1'b1; din = d; din_last = l;
    tick();
    wr_en = 1'b0; din_last = 1'b0;
  endtask

  task automatic pop_chk(input logic [15:0] ed, input logic el, input string nm);
    int w;
    w = 0;
    while (empty && w < 20) begin tick(); w++; end
    chk({nm, "_valid"}, empty, 1'b0);
    chk({nm, "_data"}, {dout_last, dout}, {el, ed});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int nz;
  int w;

  initial begin
    rst = 1'b1; wr_en = 1'b0; din = '0; din_last = 1'b0; wr_abort = 1'b0; rd_en = 1'b0;
    mode_limit = 1'b0; reg_output_limit = 1'b0;
    s_wr_en = 1'b0; s_din = '0; s_din_last = 1'b0; s_wr_abort = 1'b0; s_rd_en = 1'b0;
    s_mode = 1'b0; s_reg = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_olim", output_limit, 16'd0);
    chk("rst_nd", output_limit_not_done, 1'b0);
    chk("rst_err", err_pkt_overflow, 1'b0);

    // 1: release latency and ordering
    wr(16'hA1, 1'b0); wr(16'hA2, 1'b0); wr(16'hA3, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t1_lat%0d", k), empty, 32'(k < 4));
    end
    pop_chk(16'hA1, 1'b0, "t1_a1");
    pop_chk(16'hA2, 1'b0, "t1_a2");
    pop_chk(16'hA3, 1'b1, "t1_a3");
    tick();
    chk("t1_empty_after", empty, 1'b1);

    // 2: uncommitted words stay hidden
    wr(16'h21, 1'b0); wr(16'h22, 1'b0);
    nz = 0;
    repeat (100) begin tick(); if (!empty) nz++; end
    chk("t2_hold", nz, 0);
    wr(16'h23, 1'b1);
    pop_chk(16'h21, 1'b0, "t2_w1");
    pop_chk(16'h22, 1'b0, "t2_w2");
    pop_chk(16'h23, 1'b1, "t2_w3");

    // 3: limit mode grant
    mode_limit = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) wr(16'(16'h30 + i), (i % 4) == 3);
    tick(); tick();
    chk("t3_hold", empty, 1'b1);
    reg_output_limit = 1'b1; tick(); reg_output_limit = 1'b0;
    tick();
    chk("t3_olim", output_limit, 16'd8);
    chk("t3_nd", output_limit_not_done, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk(16'(16'h30 + i), (i % 4) == 3, "t3_pop");
    tick(); tick();
    chk("t3_nd_done", output_limit_not_done, 1'b0);
    wr(16'hC1, 1'b0); wr(16'hC2, 1'b1);
    repeat (10) tick();
    chk("t3_nogrant", empty, 1'b1);
    mode_limit = 1'b0;
    pop_chk(16'hC1, 1'b0, "t3_c1");
    pop_chk(16'hC2, 1'b1, "t3_c2");

    // 4: abort drops the partial packet, including a write in the abort cycle
    for (int i = 0; i < 5; i++) wr(16'(16'h50 + i), i == 4);
    for (int i = 0; i < 3; i++) wr(16'(16'h60 + i), 1'b0);
    wr_abort = 1'b1; wr_en = 1'b1; din = 16'h63;
    tick();
    wr_abort = 1'b0; wr_en = 1'b0;
    wr(16'hB0, 1'b1);
    for (int i = 0; i < 5; i++) pop_chk(16'(16'h50 + i), i == 4, "t4_pkt");
    pop_chk(16'hB0, 1'b1, "t4_b0");
    tick();
    chk("t4_err", err_pkt_overflow, 1'b0);
    chk("t4_empty", empty, 1'b1);

    // 5: oversize packet on the 16-entry instance
    s_wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_din = 16'(16'h70 + i);
      tick();
      if (i == 14) begin
        chk("t5_full15", s_full, 1'b1);
        chk("t5_err_pre", s_err, 1'b0);
      end
    end
    s_wr_en = 1'b0;
    chk("t5_err", s_err, 1'b1);
    chk("t5_full_after", s_full, 1'b0);
    repeat (10) tick();
    chk("t5_empty", s_empty, 1'b1);
    s_wr_en = 1'b1; s_din = 16'hD1; s_din_last = 1'b0; tick();
    s_din = 16'hD2; s_din_last = 1'b1; tick();
    s_wr_en = 1'b0; s_din_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = 0;
      while (s_empty && w < 20) begin tick(); w++; end
      chk("t5_valid", s_empty, 1'b0);
      chk("t5_data", {s_dout_last, s_dout}, {i == 1, 16'(16'hD1 + i)});
      s_rd_en = 1'b1; tick(); s_rd_en = 1'b0;
    end
    tick();
    chk("t5_drained", s_empty, 1'b1);
    chk("t5_err_sticky", s_err, 1'b1);

    // 6: reset in the middle of a granted read
    mode_limit = 1'b1;
    for (int i = 0; i < 6; i++) wr(16'(16'h90 + i), i == 5);
    tick();
    reg_output_limit = 1'b1; tick(); reg_output_limit = 1'b0;
    pop_chk(16'h90, 1'b0, "t6_p0");
    pop_chk(16'h91, 1'b0, "t6_p1");
    rst = 1'b1;
    tick();
    chk("t6_rst_empty", empty, 1'b1);
    chk("t6_rst_full", full, 1'b1);
    tick();
    rst = 1'b0; mode_limit = 1'b0;
    tick();
    chk("t6_nd", output_limit_not_done, 1'b0);
    chk("t6_olim", output_limit, 16'd0);
    chk("t6_err", err_pkt_overflow, 1'b0);
    chk("t6_small_err", s_err, 1'b0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_full", full, 1'b0);
    wr(16'hE1, 1'b0); wr(16'hE2, 1'b1);
    pop_chk(16'hE1, 1'b0, "t6_e1");
    pop_chk(16'hE2, 1'b1, "t6_e2");

    // Randomized traffic in both modes, checked every cycle by the model
    for (int ph = 0; ph < 2; ph++) begin
      mode_limit = (ph == 1);
      for (int c = 0; c < 600; c++) begin
        wr_en    = 1'($urandom_range(0, 1));
        din      = 16'($urandom);
        din_last = ($urandom_range(0, 3) == 0);
        wr_abort = ($urandom_range(0, 19) == 0);
        rd_en    = ($urandom_range(0, 9) < 7);
        reg_output_limit = (ph == 1) && (rel.size() == 0) && ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    wr_en = 1'b0; din_last = 1'b0; wr_abort = 1'b0; reg_output_limit = 1'b0;
    mode_limit = 1'b0; rd_en = 1'b1;
    repeat (60) tick();
    rd_en = 1'b0;
    chk("rand_drained", 32'(rel.size()), 0);
    chk("rand_empty", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
